// File: rtl/axi_sim_dut.sv
// AXI4-Lite traffic subsystem: fixed write/read-back master, scoreboarding passthrough, slave memory.
// Define AXI_SIM_PT_REG_EN to insert a full register slice on all five passthrough channels.
module axi_sim_dut #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_TXN   = 16,
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       start,
  input  logic       inject_err,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] wr_count,
  output logic [7:0] rd_count,
  output logic [7:0] err_count
);
  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned MemAw = $clog2(MEM_DEPTH);
  localparam int unsigned IdxW  = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;
  localparam logic [1:0] RespOkay = 2'b00, RespSlverr = 2'b10;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr >> (MemAw + 2)) == '0;
  endfunction

  function automatic logic [MemAw-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr[MemAw+1:2];
  endfunction

  logic              m_awvalid, m_awready, s_awvalid, s_awready;
  logic [ADDR_W-1:0] m_awaddr, s_awaddr, m_araddr, s_araddr;
  logic              m_wvalid, m_wready, s_wvalid, s_wready;
  logic [DATA_W-1:0] m_wdata, s_wdata, m_rdata, s_rdata;
  logic [StrbW-1:0]  m_wstrb, s_wstrb;
  logic              m_bvalid, m_bready, s_bvalid, s_bready;
  logic [1:0]        m_bresp, s_bresp, m_rresp, s_rresp;
  logic              m_arvalid, m_arready, s_arvalid, s_arready;
  logic              m_rvalid, m_rready, s_rvalid, s_rready;

  // ---------------- master ----------------
  typedef enum logic [2:0] {StIdle, StWaddr, StWresp, StRaddr, StRdata} state_e;
  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            awvalid_q, wvalid_q, arvalid_q, busy_q, done_q;
  logic            start_acc;

  assign start_acc = start && (state_q == StIdle);
  assign m_awvalid = awvalid_q;
  assign m_wvalid  = wvalid_q;
  assign m_arvalid = arvalid_q;
  assign m_awaddr  = ADDR_W'(idx_q) << 2;
  assign m_araddr  = ADDR_W'(idx_q) << 2;
  assign m_wdata   = DATA_W'(32'hA5A5_0000) | DATA_W'(idx_q);
  assign m_wstrb   = '1;
  assign m_bready  = 1'b1;
  assign m_rready  = 1'b1;

  // The final R handshake goes straight back to idle with done set.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (start) begin
          state_q   <= StWaddr;
          idx_q     <= '0;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
        end
        StWaddr: begin
          if (m_awready) awvalid_q <= 1'b0;
          if (m_wready) wvalid_q <= 1'b0;
          if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) state_q <= StWresp;
        end
        StWresp: if (m_bvalid) begin
          if (idx_q == IdxW'(NUM_TXN - 1)) begin
            state_q   <= StRaddr;
            idx_q     <= '0;
            arvalid_q <= 1'b1;
          end else begin
            state_q   <= StWaddr;
            idx_q     <= idx_q + 1'b1;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
          end
        end
        StRaddr: if (m_arready) begin
          arvalid_q <= 1'b0;
          state_q   <= StRdata;
        end
        StRdata: if (m_rvalid) begin
          if (idx_q == IdxW'(NUM_TXN - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= StRaddr;
            idx_q     <= idx_q + 1'b1;
            arvalid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------- passthrough ----------------
`ifdef AXI_SIM_PT_REG_EN
  localparam int unsigned PW = (ADDR_W > DATA_W + StrbW + 2) ? ADDR_W : DATA_W + StrbW + 2;
  // Channel order: 0 AW, 1 W, 2 AR (master->slave), 3 B, 4 R (slave->master).
  logic [4:0]    sl_in_v, sl_in_r, sl_out_v, sl_out_r;
  logic [PW-1:0] sl_in_d  [5];
  logic [PW-1:0] sl_out_d [5];

  assign sl_in_v    = {s_rvalid, s_bvalid, m_arvalid, m_wvalid, m_awvalid};
  assign sl_out_r   = {m_rready, m_bready, s_arready, s_wready, s_awready};
  assign sl_in_d[0] = PW'(m_awaddr);
  assign sl_in_d[1] = PW'({m_wstrb, m_wdata});
  assign sl_in_d[2] = PW'(m_araddr);
  assign sl_in_d[3] = PW'(s_bresp);
  assign sl_in_d[4] = PW'({s_rresp, s_rdata});

  assign m_awready = sl_in_r[0];
  assign m_wready  = sl_in_r[1];
  assign m_arready = sl_in_r[2];
  assign s_bready  = sl_in_r[3];
  assign s_rready  = sl_in_r[4];
  assign s_awvalid = sl_out_v[0];
  assign s_wvalid  = sl_out_v[1];
  assign s_arvalid = sl_out_v[2];
  assign m_bvalid  = sl_out_v[3];
  assign m_rvalid  = sl_out_v[4];
  assign s_awaddr           = sl_out_d[0][ADDR_W-1:0];
  assign {s_wstrb, s_wdata} = sl_out_d[1][DATA_W+StrbW-1:0];
  assign s_araddr           = sl_out_d[2][ADDR_W-1:0];
  assign m_bresp            = sl_out_d[3][1:0];
  assign {m_rresp, m_rdata} = sl_out_d[4][DATA_W+1:0];

  // Skid buffer: input ready comes only from a flop, so no ready path crosses the slice.
  for (genvar c = 0; c < 5; c++) begin : g_slice
    logic          out_v_q, skid_v_q;
    logic [PW-1:0] out_d_q, skid_d_q;

    assign sl_in_r[c]  = !skid_v_q;
    assign sl_out_v[c] = out_v_q;
    assign sl_out_d[c] = out_d_q;

    always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
        out_v_q  <= 1'b0;
        skid_v_q <= 1'b0;
        out_d_q  <= '0;
        skid_d_q <= '0;
      end else if (sl_out_r[c] || !out_v_q) begin
        if (skid_v_q) begin
          out_v_q  <= 1'b1;
          out_d_q  <= skid_d_q;
          skid_v_q <= 1'b0;
        end else begin
          out_v_q <= sl_in_v[c];
          out_d_q <= sl_in_d[c];
        end
      end else if (sl_in_v[c] && !skid_v_q) begin
        skid_v_q <= 1'b1;
        skid_d_q <= sl_in_d[c];
      end
    end
  end
`else
  assign s_awvalid = m_awvalid;
  assign s_awaddr  = m_awaddr;
  assign m_awready = s_awready;
  assign s_wvalid  = m_wvalid;
  assign s_wdata   = m_wdata;
  assign s_wstrb   = m_wstrb;
  assign m_wready  = s_wready;
  assign m_bvalid  = s_bvalid;
  assign m_bresp   = s_bresp;
  assign s_bready  = m_bready;
  assign s_arvalid = m_arvalid;
  assign s_araddr  = m_araddr;
  assign m_arready = s_arready;
  assign m_rvalid  = s_rvalid;
  assign m_rdata   = s_rdata;
  assign m_rresp   = s_rresp;
  assign s_rready  = m_rready;
`endif

  logic [DATA_W-1:0] shadow_q [MEM_DEPTH];
  logic [MemAw-1:0]  rd_idx_q;
  logic [7:0]        wr_q, rd_q, err_q, err_d;
  logic              wr_hs, b_hs, ar_hs, r_hs, b_err, r_err;
  logic [8:0]        err_sum;

  assign wr_hs = s_awvalid && s_awready && s_wvalid && s_wready;
  assign b_hs  = m_bvalid && m_bready;
  assign ar_hs = m_arvalid && m_arready;
  assign r_hs  = m_rvalid && m_rready;

  always_comb begin
    b_err   = b_hs && (m_bresp != RespOkay);
    r_err   = r_hs && ((m_rresp != RespOkay) || (m_rdata != shadow_q[rd_idx_q]));
    err_sum = {1'b0, err_q} + 9'(b_err) + 9'(r_err);
    err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      wr_q     <= '0;
      rd_q     <= '0;
      err_q    <= '0;
      rd_idx_q <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) shadow_q[i] <= '0;
    end else begin
      if (start_acc) begin
        wr_q  <= '0;
        rd_q  <= '0;
        err_q <= '0;
      end else begin
        if (b_hs) wr_q <= wr_q + 8'd1;
        if (r_hs) rd_q <= rd_q + 8'd1;
        err_q <= err_d;
      end
      if (wr_hs && in_range(s_awaddr)) begin
        for (int unsigned b = 0; b < StrbW; b++) begin
          if (s_wstrb[b]) shadow_q[word_idx(s_awaddr)][8*b +: 8] <= s_wdata[8*b +: 8];
        end
      end
      if (ar_hs) rd_idx_q <= word_idx(m_araddr);
    end
  end

  // ---------------- slave ----------------
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic              aw_rdy_q, bvalid_q, ar_rdy_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic              sl_wr_hs, sl_rd_hs;

  assign s_awready = aw_rdy_q;
  assign s_wready  = aw_rdy_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = ar_rdy_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q ^ DATA_W'(inject_err);
  assign sl_wr_hs  = aw_rdy_q && s_awvalid && s_wvalid;
  assign sl_rd_hs  = ar_rdy_q && s_arvalid;

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      aw_rdy_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RespOkay;
      ar_rdy_q <= 1'b0;
      rvalid_q <= 1'b0;
      rresp_q  <= RespOkay;
      rdata_q  <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      aw_rdy_q <= s_awvalid && s_wvalid && !bvalid_q && !aw_rdy_q;
      ar_rdy_q <= s_arvalid && !rvalid_q && !ar_rdy_q;
      if (s_bready) bvalid_q <= 1'b0;
      if (s_rready) rvalid_q <= 1'b0;
      if (sl_wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= in_range(s_awaddr) ? RespOkay : RespSlverr;
        if (in_range(s_awaddr)) begin
          for (int unsigned b = 0; b < StrbW; b++) begin
            if (s_wstrb[b]) mem_q[word_idx(s_awaddr)][8*b +: 8] <= s_wdata[8*b +: 8];
          end
        end
      end
      if (sl_rd_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= in_range(s_araddr) ? RespOkay : RespSlverr;
        rdata_q  <= in_range(s_araddr) ? mem_q[word_idx(s_araddr)] : '0;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (err_q == 8'd0);
  assign wr_count  = wr_q;
  assign rd_count  = rd_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_axi_sim_dut.sv
// Directed bench for axi_sim_dut: run results are queued at start and checked when done rises.
module tb_axi_sim_dut;
`ifdef AXI_SIM_PT_REG_EN
  localparam int Per = 5;
`else
  localparam int Per = 3;
`endif

  logic       clk = 1'b0;
  logic       rst, start1, start2, inj;
  logic       busy1, done1, pass1, busy2, done2, pass2;
  logic [7:0] wr1, rd1, err1, wr2, rd2, err2;
  logic       o_busy, o_done, o_pass;
  logic [7:0] o_wr, o_rd, o_err;
  int         sel;
  int         n_vec = 0;
  int         n_miss = 0;

  typedef struct {
    string tag;
    int    cyc;
    int    wr;
    int    rd;
    int    err;
    int    pass_v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  axi_sim_dut u_dut (
    .aclk(clk), .aresetn(rst), .start(start1), .inject_err(inj),
    .busy(busy1), .done(done1), .pass(pass1),
    .wr_count(wr1), .rd_count(rd1), .err_count(err1)
  );

  axi_sim_dut #(.NUM_TXN(20), .MEM_DEPTH(16)) u_dut20 (
    .aclk(clk), .aresetn(rst), .start(start2), .inject_err(inj),
    .busy(busy2), .done(done2), .pass(pass2),
    .wr_count(wr2), .rd_count(rd2), .err_count(err2)
  );

  always_comb begin
    o_busy = (sel == 0) ? busy1 : busy2;
    o_done = (sel == 0) ? done1 : done2;
    o_pass = (sel == 0) ? pass1 : pass2;
    o_wr   = (sel == 0) ? wr1 : wr2;
    o_rd   = (sel == 0) ? rd1 : rd2;
    o_err  = (sel == 0) ? err1 : err2;
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic run(input string tag, input int which, input int n, input int errs,
                     input bit inj_rd, input bit mid_start);
    exp_t e;
    int   cyc;
    sel = which;
    e.tag = tag;
    e.cyc = 2 * Per * n + 1;
    e.wr = n;
    e.rd = n;
    e.err = errs;
    e.pass_v = (errs == 0) ? 1 : 0;
    sb.push_back(e);
    @(negedge clk);
    if (which == 0) start1 = 1'b1;
    else start2 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    cyc = 1;
    check({tag, "_busy"}, int'(o_busy), 1);
    check({tag, "_clr_done"}, int'(o_done), 0);
    check({tag, "_clr_wr"}, int'(o_wr), 0);
    while (!o_done && cyc < 2 * Per * n + 50) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inj_rd && int'(o_wr) == n) inj = 1'b1;
      if (mid_start) start1 = (cyc == 20);
    end
    inj = 1'b0;
    start1 = 1'b0;
    e = sb.pop_front();
    check({e.tag, "_done"}, int'(o_done), 1);
    check({e.tag, "_cycles"}, cyc, e.cyc);
    check({e.tag, "_wr"}, int'(o_wr), e.wr);
    check({e.tag, "_rd"}, int'(o_rd), e.rd);
    check({e.tag, "_err"}, int'(o_err), e.err);
    check({e.tag, "_pass"}, int'(o_pass), e.pass_v);
    check({e.tag, "_idle"}, int'(o_busy), 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start1 = 1'b0;
    start2 = 1'b0;
    inj = 1'b0;
    sel = 0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy", int'(busy1), 0);
    check("rst_done", int'(done1), 0);
    check("rst_pass", int'(pass1), 0);
    check("rst_counts", int'({wr1, rd1, err1}), 0);
    @(negedge clk);
    rst = 1'b0;

    run("basic", 0, 16, 0, 1'b0, 1'b0);
    run("inject", 0, 16, 16, 1'b1, 1'b0);
    run("busy_start", 0, 16, 0, 1'b0, 1'b1);
    run("rerun", 0, 16, 0, 1'b0, 1'b0);

    // Abort during write 7, asynchronously between clock edges.
    sel = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    cyc = 0;
    while (int'(wr1) != 7 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abort_reach_w7", int'(wr1), 7);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy1), 0);
    check("abort_done_pass", int'({done1, pass1}), 0);
    check("abort_counts", int'({wr1, rd1, err1}), 0);
    @(negedge clk);
    rst = 1'b0;

    run("after_rst", 0, 16, 0, 1'b0, 1'b0);
    run("slverr", 1, 20, 8, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/axi_sim_dut.md
# axi_sim_dut

Self-contained AXI4-Lite traffic subsystem: an internal master issues a fixed write-then-read-back sequence through a passthrough monitor stage into an internal slave memory. The passthrough stage scoreboards every read against the data previously written to the same address. It sits under the simulation top as the single block design driven only by clock, reset and a few control/status pins.

## Interface
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; WSTRB is DATA_W/8 bits.
- NUM_TXN, 16, writes per run; the same number of reads follows.
- MEM_DEPTH, 16, slave memory words; power of two, ≥ NUM_TXN.

Ports:
- aclk  in  1  single clock; all logic on its rising edge.
- aresetn  in  1  reset, asynchronous, active-high (despite the name).
- start  in  1  one-cycle pulse that begins a run.
- inject_err  in  1  while 1, slave inverts RDATA bit 0.
- busy  out  1  run in progress.
- done  out  1  set after the last read completes; held until next start or reset.
- pass  out  1  valid with done: 1 when err_count == 0.
- wr_count  out  8  completed write transactions (B handshakes).
- rd_count  out  8  completed read transactions (R handshakes).
- err_count  out  8  read-data mismatches plus non-OKAY responses; saturates at 255.

## Operation
- Internal channels: AXI4-Lite AW, W, B, AR, R with VALID/READY.
  - Master BREADY and RREADY are tied to 1.
  - A transfer occurs when VALID and READY are both high on a rising edge.
- Master FSM states: IDLE → WADDR → WRESP → (next write, or RADDR after NUM_TXN writes) → RDATA → (next read, or DONE).
  - DONE returns to IDLE in the same cycle.
  - start is accepted only in IDLE; start while busy is ignored.
- Write i (i = 0..NUM_TXN-1):
  - AWADDR = 4·i, WDATA = 32'hA5A5_0000 | i, WSTRB = all ones.
  - AWVALID and WVALID assert together and each holds until its own handshake.
- Read i: ARADDR = 4·i.
- Slave:
  - Asserts AWREADY and WREADY for one cycle only when AWVALID, WVALID and no pending B are all present.
  - Writes the memory, honouring WSTRB, then asserts BVALID on the next cycle.
  - ARREADY is a one-cycle pulse when ARVALID is high and no R is pending.
  - RVALID comes on the next cycle, with RDATA = mem[ARADDR[log2(MEM_DEPTH)+1:2]].
  - Word index = ADDR[log2(MEM_DEPTH)+1:2]. An address whose word index ≥ MEM_DEPTH gets SLVERR with no write and RDATA = 0; otherwise the response is OKAY.
- Passthrough:
  - Forwards all channel signals unchanged, master-to-slave and slave-to-master.
  - Keeps a shadow copy of each accepted write, indexed by word address.
  - On each R handshake it compares RDATA with the shadow copy. A mismatch, or a BRESP/RRESP ≠ OKAY, increments err_count.
  - Counters increment on handshakes observed at the passthrough.
- start in IDLE clears the counters, done and pass, and sets busy.
- Reset: all VALID/READY low, FSM in IDLE, busy/done/pass = 0, counters = 0. Slave memory and shadow copy are cleared to 0.
- Reset mid-run aborts the run immediately and leaves no partial state. The next start replays from i = 0.

## Timing
- Combinational passthrough, write (T = cycle AWVALID rises):
  - AW/W handshake at T+1, B handshake at T+2.
  - Next AWVALID at T+3, so each write takes 3 cycles.
- Reads follow the same 3-cycle pattern.
- The first AWVALID appears the cycle after start is sampled.
- done rises the cycle after the final R handshake. Total run = 6·NUM_TXN + 1 cycles (97 for defaults).
- wr_count and rd_count update the cycle after their handshake.
- err_count updates the cycle after the offending R/B handshake.

## Configuration
- AXI_SIM_PT_REG_EN defined: the passthrough inserts a full register slice (one stage per direction) on all five channels.
  - Each transaction gets 2 extra cycles: 5 per write or read, 10·NUM_TXN + 1 per run (161 default).
  - No bubbles at steady state, and no combinational path from slave READY to master READY.
- Undefined: purely combinational passthrough with the timing above.
- Functional results (counts, pass) are identical in both builds.

## Test plan
- Reset asserted 5 cycles, then pulse start, inject_err = 0:
  - done at cycle 97 (161 with AXI_SIM_PT_REG_EN).
  - wr_count = 16, rd_count = 16, err_count = 0, pass = 1.
- Same run with inject_err = 1 during the read phase: err_count = 16, pass = 0.
- start pulsed again while busy: ignored, final counts unchanged at 16/16.
- Reset asserted during write 7: all outputs 0 asynchronously. A following start completes normally with pass = 1.
- Second start after done: counters clear to 0 on start, run repeats with identical results.
- Build with NUM_TXN = 20, MEM_DEPTH = 16: writes/reads 16–19 get SLVERR, err_count = 8, pass = 0.
